sentry_trace_packer: RTL and testbench
======================================

Name: sentry_trace_packer

Overview:
- Core-side producer for the sentry trace FIFO.
- Collects committed instructions from the main core one at a time, as an (instruction, result) pair.
- Packs four consecutive commits, oldest first, into one quad_trace_s word and pushes it into the trace FIFO under full-flag back pressure.
- Back pressure reaches the core's commit stage through commit_stall. The sentry control reconstructs PCs from an unbroken stream, so this block never pads, drops or reorders a commit.

Parameters:
- SENTRY_WIDTH, 4, instructions per trace word. Only 4 is supported.
- X_LEN, 64, width of the result field (data_t).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- commit_valid  input  1  one committed instruction this cycle.
- commit_inst  input  32  committed instruction word (inst_t).
- commit_result  input  X_LEN  result: ALU/load value, or target address for JAL/JALR/taken branch.
- commit_stall  output  1  core must hold its commit this cycle.
- trace_full  input  1  trace FIFO full.
- trace_push  output  1  FIFO write enable.
- trace_data  output  quad_trace_s  packed word; trace0 is the oldest commit.
- quad_count  output  32  number of words pushed since reset; wraps.
- overflow_err  output  1  sticky: a commit arrived while stalled.

Behaviour:
- State:
  - asm_cnt: 0..3.
  - asm_slot[0..2]: registered {inst, result}.
  - out_full: output register holds a word.
  - out_word.
  - quad_count.
  - overflow_err.
- Reset: asm_cnt=0, out_full=0, so trace_push=0. quad_count=0, overflow_err=0. trace_data contents don't-care while out_full=0.
- trace_push = out_full && !trace_full (combinational). When high, the word is consumed this cycle.
- out_free = !out_full || trace_push.
- commit_stall = (asm_cnt==3) && !out_free (combinational).
- accept = commit_valid && !commit_stall.
- accept with asm_cnt<3: write asm_slot[asm_cnt]; asm_cnt += 1.
- accept with asm_cnt==3:
  - out_word <= {asm_slot0, asm_slot1, asm_slot2, current commit} as trace0..trace3.
  - out_full <= 1; asm_cnt <= 0.
  - Latency: 4th commit in cycle T gives trace_push in T+1 if trace_full=0.
- trace_push without a new word completing: out_full <= 0.
- Push and new word in the same cycle: out_full stays 1 and out_word is replaced. Sustained throughput is one word per 4 commits, with no bubble.
- quad_count increments on every trace_push and wraps 0xFFFFFFFF to 0.
- commit_valid && commit_stall: commit ignored, state unchanged, overflow_err <= 1. overflow_err is cleared only by rst.
- Stalls can only occur with asm_cnt==3. Slots 0..2 are never overwritten while held.
- trace_full may toggle arbitrarily. out_word is stable while out_full && trace_full.
- rst mid-operation: partial group and pending word are discarded, counters cleared. trace_push is low in the cycle after rst.
- No flush or padding. A partial group stays in the packer until its 4th commit arrives.

Test Plan:
- Basic pack: reset, trace_full=0; commit inst 0x00000013 (ADDI) with results 1,2,3,4 on consecutive cycles. Required: trace_push=1 exactly one cycle after the 4th commit; trace0..3 results = 1,2,3,4 in order; quad_count=1; commit_stall never asserted.
- Streaming: 400 back-to-back commits with result=i and trace_full=0. Required: 100 pushes; push k carries results 4k..4k+3; no stall; quad_count=100.
- Back pressure: hold trace_full=1 and issue 8 commits. Required:
  - word 0 held, trace_data stable;
  - commit_stall=1 from the cycle asm_cnt reaches 3 in the second group (commit 8 held);
  - after release, words 0 and 1 pushed in order, then commit 8 is accepted;
  - no data lost; overflow_err=0.
- Overflow: during the stall above, drive commit_valid=1 while ignoring commit_stall. Required: overflow_err=1 and stays 1; the offending commit is absent from all later words.
- Simultaneous push and refill: trace_full=0 with the output register full, and the 4th commit of the next group in the same cycle. Required: old word pushed that cycle; new word pushed the next cycle; no bubble and no stall.
- Reset mid-group: 2 commits, then rst, then 4 commits with results 0xA..0xD. Required: first pushed word = A,B,C,D; quad_count=1.

Source files
------------

// File: rtl/sentry_trace_packer_if.sv
// Commit-side and trace-FIFO-side signals of the sentry trace packer.
// Master is the core/FIFO environment; slave is the packer.
interface sentry_trace_if #(
   parameter int SENTRY_WIDTH = 4,
   parameter int X_LEN        = 64
);
   localparam int TW = SENTRY_WIDTH * (32 + X_LEN);

   logic             commit_valid;
   logic [31:0]      commit_inst;
   logic [X_LEN-1:0] commit_result;
   logic             commit_stall;
   logic             trace_full;
   logic             trace_push;
   logic [TW-1:0]    trace_data;
   logic [31:0]      quad_count;
   logic             overflow_err;

   modport master (
      output commit_valid, commit_inst, commit_result, trace_full,
      input  commit_stall, trace_push, trace_data, quad_count,
      input  overflow_err
   );

   modport slave (
      input  commit_valid, commit_inst, commit_result, trace_full,
      output commit_stall, trace_push, trace_data, quad_count,
      output overflow_err
   );
endinterface

// File: rtl/sentry_trace_packer.sv
// Packs four consecutive commits, oldest first, into one trace word
// and pushes it to the sentry trace FIFO under full-flag back pressure.
module sentry_trace_packer #(
   parameter int SENTRY_WIDTH = 4,
   parameter int X_LEN        = 64
) (
   input logic          clk,
   input logic          rst,
   sentry_trace_if.slave bus
);
   typedef logic [31:0]      inst_t;
   typedef logic [X_LEN-1:0] data_t;

   typedef struct packed {
      inst_t inst;
      data_t result;
   } trace_s;

   typedef struct packed {
      trace_s trace0;
      trace_s trace1;
      trace_s trace2;
      trace_s trace3;
   } quad_trace_s;

   localparam int TW = SENTRY_WIDTH * $bits(trace_s);

   logic [1:0]    r_cnt;
   trace_s        r_slot [3];
   logic          r_out_full;
   logic [TW-1:0] r_out_word;
   logic [31:0]   r_qcnt;
   logic          r_ovf;

   logic        w_push;
   logic        w_free;
   logic        w_stall;
   logic        w_accept;
   logic        w_done;
   trace_s      w_cur;
   quad_trace_s w_quad;

   assign w_cur    = {bus.commit_inst, bus.commit_result};
   assign w_push   = r_out_full && !bus.trace_full;
   assign w_free   = !r_out_full || w_push;
   assign w_stall  = (r_cnt == 2'd3) && !w_free;
   assign w_accept = bus.commit_valid && !w_stall;
   assign w_done   = w_accept && (r_cnt == 2'd3);
   assign w_quad   = {r_slot[0], r_slot[1], r_slot[2], w_cur};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= 2'd0;
         r_out_full <= 1'b0;
         r_qcnt     <= 32'd0;
         r_ovf      <= 1'b0;
      end else begin
         // counter wraps 3 -> 0 exactly when a word completes
         if (w_accept)
            r_cnt <= r_cnt + 2'd1;
         if (w_done)
            r_out_full <= 1'b1;
         else if (w_push)
            r_out_full <= 1'b0;
         if (w_push)
            r_qcnt <= r_qcnt + 32'd1;
         if (bus.commit_valid && w_stall)
            r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (w_accept && r_cnt == 2'(i))
            r_slot[i] <= w_cur;
      end
      if (w_done)
         r_out_word <= w_quad;
   end

   assign bus.trace_push   = w_push;
   assign bus.trace_data   = r_out_word;
   assign bus.commit_stall = w_stall;
   assign bus.quad_count   = r_qcnt;
   assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_sentry_trace_packer.sv
// Randomized and directed bench for sentry_trace_packer against a
// queue-based model of the commit stream and pending trace words.
module tb_sentry_trace_packer;
   localparam int XL = 64;
   localparam int EW = 32 + XL;
   localparam int TW = 4 * EW;
   localparam logic [31:0] ADDI = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sentry_trace_if #(.SENTRY_WIDTH(4), .X_LEN(XL)) bus ();

   sentry_trace_packer #(.SENTRY_WIDTH(4), .X_LEN(XL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [EW-1:0] m_part  [$];
   logic [TW-1:0] m_words [$];
   logic [31:0]   m_qc  = 32'd0;
   logic          m_ovf = 1'b0;

   task automatic check(string name, logic [TW-1:0] act,
                        logic [TW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [XL-1:0] res_of(logic [TW-1:0] w, int k);
      return w[TW-1-k*EW-32 -: XL];
   endfunction

   function automatic logic [31:0] inst_of(logic [TW-1:0] w, int k);
      return w[TW-1-k*EW -: 32];
   endfunction

   // model: accepted commits not yet grouped, and completed words waiting
   always @(negedge clk) begin
      logic m_push;
      logic m_stall;
      if (chk_en) begin
         m_push  = (m_words.size() > 0) && !bus.trace_full;
         m_stall = (m_part.size() == 3) && (m_words.size() > 0) && !m_push;
         check("push", TW'(bus.trace_push), TW'(m_push));
         check("stall", TW'(bus.commit_stall), TW'(m_stall));
         check("quad_count", TW'(bus.quad_count), TW'(m_qc));
         check("overflow", TW'(bus.overflow_err), TW'(m_ovf));
         if (m_words.size() > 0)
            check("data", bus.trace_data, m_words[0]);
         if (rst) begin
            m_part.delete();
            m_words.delete();
            m_qc  = 32'd0;
            m_ovf = 1'b0;
         end else begin
            if (bus.commit_valid && m_stall)
               m_ovf = 1'b1;
            if (m_push) begin
               void'(m_words.pop_front());
               m_qc = m_qc + 32'd1;
            end
            if (bus.commit_valid && !m_stall) begin
               m_part.push_back({bus.commit_inst, bus.commit_result});
               if (m_part.size() == 4) begin
                  m_words.push_back({m_part[0], m_part[1],
                                     m_part[2], m_part[3]});
                  m_part.delete();
               end
            end
         end
      end
   end

   task automatic step(logic v, logic [XL-1:0] res, logic full);
      @(posedge clk);
      #1;
      rst               = 1'b0;
      bus.trace_full    = full;
      bus.commit_valid  = v;
      bus.commit_inst   = ADDI;
      bus.commit_result = res;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TW-1:0] held;
      int pushes;
      int stalls;
      logic v;

      bus.commit_valid  = 1'b0;
      bus.commit_inst   = 32'd0;
      bus.commit_result = '0;
      bus.trace_full    = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      #1;
      check("reset_push", TW'(bus.trace_push), TW'(0));
      check("reset_qc", TW'(bus.quad_count), TW'(0));
      check("reset_ovf", TW'(bus.overflow_err), TW'(0));

      // basic pack
      for (int i = 1; i <= 4; i++)
         step(1'b1, XL'(i), 1'b0);
      check("basic_early", TW'(bus.trace_push), TW'(0));
      step(1'b0, '0, 1'b0);
      check("basic_push", TW'(bus.trace_push), TW'(1));
      for (int k = 0; k < 4; k++)
         check("basic_res", TW'(res_of(bus.trace_data, k)), TW'(k + 1));
      check("basic_inst", TW'(inst_of(bus.trace_data, 0)), TW'(ADDI));
      step(1'b0, '0, 1'b0);
      check("basic_done", TW'(bus.trace_push), TW'(0));
      check("basic_qc", TW'(bus.quad_count), TW'(1));

      // streaming
      pushes = 0;
      stalls = 0;
      for (int i = 0; i < 400; i++) begin
         step(1'b1, XL'(i), 1'b0);
         pushes += int'(bus.trace_push);
         stalls += int'(bus.commit_stall);
      end
      step(1'b0, '0, 1'b0);
      pushes += int'(bus.trace_push);
      step(1'b0, '0, 1'b0);
      check("stream_pushes", TW'(pushes), TW'(100));
      check("stream_stalls", TW'(stalls), TW'(0));
      check("stream_qc", TW'(bus.quad_count), TW'(101));

      // back pressure, core honours the stall
      for (int i = 0; i < 7; i++)
         step(1'b1, XL'(32'h100 + i), 1'b1);
      held = bus.trace_data;
      check("bp_word0", TW'(res_of(held, 0)), TW'(32'h100));
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b1);
         check("bp_stall", TW'(bus.commit_stall), TW'(1));
         check("bp_stable", bus.trace_data, held);
      end
      step(1'b1, XL'(32'h107), 1'b0);
      check("bp_rel_push", TW'(bus.trace_push), TW'(1));
      check("bp_rel_stall", TW'(bus.commit_stall), TW'(0));
      step(1'b0, '0, 1'b0);
      check("bp_word1_push", TW'(bus.trace_push), TW'(1));
      check("bp_word1_first", TW'(res_of(bus.trace_data, 0)), TW'(32'h104));
      check("bp_word1_last", TW'(res_of(bus.trace_data, 3)), TW'(32'h107));
      check("bp_no_ovf", TW'(bus.overflow_err), TW'(0));

      // overflow: commit driven into a stall
      for (int i = 0; i < 7; i++)
         step(1'b1, XL'(32'h200 + i), 1'b1);
      step(1'b1, XL'(32'hBAD), 1'b1);
      check("ovf_stall", TW'(bus.commit_stall), TW'(1));
      step(1'b0, '0, 1'b1);
      check("ovf_set", TW'(bus.overflow_err), TW'(1));
      step(1'b1, XL'(32'h207), 1'b0);
      step(1'b0, '0, 1'b0);
      check("ovf_word_push", TW'(bus.trace_push), TW'(1));
      check("ovf_word_last", TW'(res_of(bus.trace_data, 3)), TW'(32'h207));
      step(1'b0, '0, 1'b0);
      check("ovf_sticky", TW'(bus.overflow_err), TW'(1));

      // push and refill in the same cycle
      for (int i = 0; i < 7; i++)
         step(1'b1, XL'(32'h300 + i), 1'b1);
      step(1'b1, XL'(32'h307), 1'b0);
      check("sim_push_old", TW'(bus.trace_push), TW'(1));
      check("sim_old", TW'(res_of(bus.trace_data, 0)), TW'(32'h300));
      check("sim_stall", TW'(bus.commit_stall), TW'(0));
      step(1'b0, '0, 1'b0);
      check("sim_push_new", TW'(bus.trace_push), TW'(1));
      check("sim_new", TW'(res_of(bus.trace_data, 0)), TW'(32'h304));
      step(1'b0, '0, 1'b0);
      check("sim_idle", TW'(bus.trace_push), TW'(0));

      // reset mid-group
      step(1'b1, XL'(32'h55), 1'b0);
      step(1'b1, XL'(32'h56), 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.commit_valid = 1'b0;
      @(negedge clk);
      #1;
      step(1'b0, '0, 1'b0);
      check("rst_push", TW'(bus.trace_push), TW'(0));
      check("rst_qc", TW'(bus.quad_count), TW'(0));
      check("rst_ovf", TW'(bus.overflow_err), TW'(0));
      for (int i = 0; i < 4; i++)
         step(1'b1, XL'(32'hA + i), 1'b0);
      step(1'b0, '0, 1'b0);
      check("rst_word_push", TW'(bus.trace_push), TW'(1));
      for (int k = 0; k < 4; k++)
         check("rst_word", TW'(res_of(bus.trace_data, k)), TW'(32'hA + k));
      step(1'b0, '0, 1'b0);
      check("rst_word_qc", TW'(bus.quad_count), TW'(1));

      // random traffic; the core occasionally ignores the stall
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         rst = 1'b0;
         bus.trace_full = ($urandom_range(0, 2) == 0);
         #1;
         v = ($urandom_range(0, 3) != 0) &&
             (!bus.commit_stall || $urandom_range(0, 49) == 0);
         bus.commit_valid  = v;
         bus.commit_inst   = $urandom;
         bus.commit_result = {$urandom, $urandom};
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++)
         step(1'b0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
